sumador_nbits_mod: RTL
======================

SUMADOR_NBITS_MOD -- requirements
Module: sumador_nbits_mod

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (2..16).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  advance counter by step this cycle.
REQ-006 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 step  input  WIDTH  increment/decrement magnitude.
REQ-008 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-009 load  input  1  synchronous load of load_val.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 clr_ovf  input  1  clears sticky ovf.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 ovf  output  1  sticky boundary-crossed flag.
REQ-015 done  output  1  high while FSM is in DONE.

Function
REQ-016 Effective step SHALL be min(step, MAX_VAL); effective load value SHALL be min(load_val, MAX_VAL).
REQ-017 Arithmetic SHALL use WIDTH+1 bits internally; count never exceeds MAX_VAL.
REQ-018 FSM states: RUN, DONE. RUN->DONE when a one-shot update reaches its terminal. DONE->RUN only on load. Reset -> RUN.
REQ-019 Priority per cycle: load > enable; load updates count next edge, leaves tc low, ovf unchanged.
REQ-020 In RUN with enable=1, load=0, step_eff>0, up: if count+step_eff <= MAX_VAL, count <= count+step_eff; else wrap: count+step_eff-(MAX_VAL+1); saturate/one-shot: MAX_VAL.
REQ-021 Down: if count >= step_eff, count <= count-step_eff; else wrap: count-step_eff+MAX_VAL+1; saturate/one-shot: 0.
REQ-022 Terminal = MAX_VAL (up) or 0 (down); tc SHALL pulse in the cycle the new count is visible when the update lands on or crosses terminal and count actually changes.
REQ-023 ovf SHALL set when an update strictly crosses the boundary (wrap or clamp); clr_ovf clears it; simultaneous set and clear -> set wins.
REQ-024 step_eff=0 or enable=0: count holds, tc low.
REQ-025 Saturated hold (already at terminal, moving further): count holds, tc low, ovf sets.
REQ-026 In DONE: enable ignored, count holds, tc low; mode changes do not leave DONE.
REQ-027 Direction or mode changes take effect on the same cycle's update, no pipeline latency.
REQ-028 Latency: count, tc, ovf, done all update on the clock edge after the qualifying inputs.

Reset
REQ-029 rst_n low SHALL immediately force count=0, tc=0, ovf=0, done=0, FSM=RUN, regardless of clk.
REQ-030 Deassertion mid-operation SHALL resume counting from 0 on the first enabled edge; no tc from reset itself.

Structure
REQ-031 Package sumador_pkg SHALL hold mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and FSM state encodings.
REQ-032 One combinational sub-module sumador_step_calc SHALL compute next count, hit-terminal and crossed flags; sumador_nbits_mod holds registers and FSM.

Verification (WIDTH=8, MAX_VAL=9 unless stated)
REQ-033 Wrap up: count=8, step=3, enable -> count=1, tc=1 one cycle, ovf=1.
REQ-034 Saturate down: count=2, step=5, mode=01, up_dn=0 -> count=0, tc=1, ovf=1; next enabled cycle count=0, tc=0.
REQ-035 One-shot: load 0, step=4, mode=10 -> 4, 8, 9 (tc=1, done=1); further enables hold 9; load 3 -> count=3, done=0.
REQ-036 Priority/clamp: load=1, load_val=200, enable=1 -> count=9, tc=0; clr_ovf with simultaneous crossing -> ovf stays 1.
REQ-037 Reset mid-run: count=7, ovf=1, assert rst_n low between edges -> count=0, ovf=0, done=0 immediately.
REQ-038 Default params (MAX_VAL=255): count=250, step=10 wrap -> count=4, tc=1; step=0 -> hold, tc=0.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared encodings for the sumador counter: update modes and control FSM states.
package sumador_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage

// File: rtl/sumador_step_calc.sv
// Combinational next-count calculator: applies the clamped step in the chosen
// direction and reports whether the update landed on or crossed the terminal.
module sumador_step_calc
    import sumador_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_step,
    input  logic             i_up_dn,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_tc,
    output logic             o_reach,
    output logic             o_crossed
);

    // One extra bit so neither count+step nor count+MAX_VAL+1 can overflow.
    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_VAL);

    logic [WIDTH:0] w_cnt;
    logic [WIDTH:0] w_step_eff;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_res;
    logic           w_clamp;
    logic           w_hit;
    logic           w_crossed;

    always_comb begin
        w_cnt      = {1'b0, i_count};
        w_step_eff = ({1'b0, i_step} > MAXV) ? MAXV : {1'b0, i_step};
        w_clamp    = (i_mode == MODE_SAT) || (i_mode == MODE_ONESHOT);
        w_sum      = w_cnt + w_step_eff;
        w_res      = w_cnt;
        w_hit      = 1'b0;
        w_crossed  = 1'b0;
        if (w_step_eff != '0) begin
            if (i_up_dn) begin
                if (w_sum <= MAXV) begin
                    w_res = w_sum;
                    w_hit = (w_sum == MAXV);
                end else begin
                    w_crossed = 1'b1;
                    w_res     = w_clamp ? MAXV : (w_sum - (MAXV + 1'b1));
                end
            end else begin
                if (w_cnt >= w_step_eff) begin
                    w_res = w_cnt - w_step_eff;
                    w_hit = (w_res == '0);
                end else begin
                    w_crossed = 1'b1;
                    w_res     = w_clamp ? '0 : (w_cnt + MAXV + 1'b1 - w_step_eff);
                end
            end
        end
    end

    assign o_next    = w_res[WIDTH-1:0];
    assign o_reach   = w_hit | w_crossed;
    assign o_crossed = w_crossed;
    // A saturated hold reaches the terminal without moving, so it gives no tc.
    assign o_tc      = o_reach && (o_next != i_count);

endmodule

// File: rtl/sumador_nbits_mod.sv
// Up/down counter with wrap, saturate and one-shot modes, sticky overflow
// flag and a RUN/DONE FSM that parks the counter after a one-shot terminal.
module sumador_nbits_mod
    import sumador_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] step,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_VAL);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_load_eff;
    logic [WIDTH-1:0] w_calc_next;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             w_calc_tc;
    logic             w_calc_reach;
    logic             w_calc_crossed;

    sumador_step_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_step_calc (
        .i_count   (r_count),
        .i_step    (step),
        .i_up_dn   (up_dn),
        .i_mode    (mode),
        .o_next    (w_calc_next),
        .o_tc      (w_calc_tc),
        .o_reach   (w_calc_reach),
        .o_crossed (w_calc_crossed)
    );

    assign w_load_eff = ({1'b0, load_val} > MAXV) ? MAXV[WIDTH-1:0] : load_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Load beats enable; a crossing in the same cycle as clr_ovf keeps ovf set.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_ovf_nxt   = r_ovf & ~clr_ovf;
        if (load) begin
            w_count_nxt = w_load_eff;
            w_state_nxt = ST_RUN;
        end else if (enable && (r_state == ST_RUN)) begin
            w_count_nxt = w_calc_next;
            w_tc_nxt    = w_calc_tc;
            if (w_calc_crossed) begin
                w_ovf_nxt = 1'b1;
            end
            if ((mode == MODE_ONESHOT) && w_calc_reach) begin
                w_state_nxt = ST_DONE;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;
    assign done  = (r_state == ST_DONE);

endmodule
